// File: rtl/password_tx.sv
// Serial code transmitter: shifts a latched code word out MSB-first,
// followed by a low guard gap and a one-cycle done pulse.
module password_tx #(
  parameter int WIDTH = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] code,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int MAXC = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_GAP = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    out_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          // First bit goes straight to the output flop; the rest stay queued.
          state_d = S_SEND;
          out_d   = code[WIDTH-1];
          sreg_d  = code << 1;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_SEND: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d  = '0;
          sreg_d = '0;
          if (GAP > 0) begin
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          out_d  = sreg_q[WIDTH-1];
          sreg_d = sreg_q << 1;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == LAST_GAP) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        sreg_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
